pixel_stream_tx: RTL and testbench
==================================

# pixel_stream_tx

Raster pixel-stream transmitter: reads one 640x480 RGB888 frame from a synchronous frame memory and emits it as the `pixel_out`/`HSYNC`/`VSYNC` stream the processing top consumes (a pixel is valid exactly when `HSYNC && VSYNC`). It inserts horizontal and vertical blanking and runs one frame per `start`, or back-to-back frames. It drives the processing top's input side in the FPGA build and in the bench.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `H_BLANK`, 160, blanking cycles after each line (≥1)
- `V_BLANK`, 45, blanking lines after each frame (≥1)
- `ADDR_W`, 19, frame-memory address width (≥ clog2(H_ACTIVE*V_ACTIVE))

Ports:
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to send a frame; ignored while `busy`
- `continuous`  in  1  sampled at the last cycle of a frame: 1 = restart immediately
- `mem_rd_en`  out  1  frame-memory read enable
- `mem_rd_addr`  out  ADDR_W  linear address, row*H_ACTIVE+col
- `mem_rd_data`  in  24  read data, valid the cycle after `mem_rd_en`
- `pixel_out`  out  24  RGB888 pixel, 0 outside active region
- `HSYNC`  out  1  high during active columns of active lines
- `VSYNC`  out  1  high during active lines
- `busy`  out  1  frame in progress, including pipeline drain
- `frame_done`  out  1  one-cycle pulse with the last blanking cycle of a frame

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: `start`=1 → RUN with `h_cnt`=0, `v_cnt`=0, `addr`=0.
- RUN: `h_cnt` counts 0..H_ACTIVE+H_BLANK-1, then wraps and `v_cnt` increments. `v_cnt` counts 0..V_ACTIVE+V_BLANK-1.
- Read phase: `mem_rd_en` = (`h_cnt`<H_ACTIVE && `v_cnt`<V_ACTIVE) && state==RUN. `mem_rd_addr` = `addr`. `addr` increments by 1 on each read and is never multiplied. `addr` resets to 0 at the frame wrap.
- Output stage, one register: the read-phase active flag is delayed 1 cycle. `HSYNC` = delayed (`h_cnt`<H_ACTIVE && `v_cnt`<V_ACTIVE). `VSYNC` = delayed (`v_cnt`<V_ACTIVE). `pixel_out` = `mem_rd_data` when delayed active, else 0.
- Final counter position (last blanking cycle):
  - `frame_done` pulses.
  - `continuous`=1: counters wrap to 0 and RUN continues without gaps.
  - `continuous`=0: go to DRAIN for 1 cycle, then IDLE.
- `busy` = state≠IDLE.
- `start` in RUN or DRAIN: ignored and not queued.

## Timing
- Reset values: `pixel_out`=0, `HSYNC`=0, `VSYNC`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `busy`=0, `frame_done`=0. All state is cleared asynchronously on `resetn` low, including mid-frame. After release, the block waits for a new `start`.
- `start` sampled at edge k → `mem_rd_en`=1 with addr 0 in cycle k+1 → first valid pixel (`HSYNC&&VSYNC`) in cycle k+2.
- Each line: H_ACTIVE consecutive valid cycles, then H_BLANK cycles with `HSYNC`=0. `VSYNC` stays 1 across horizontal blanking of active lines.
- Frame period: (H_ACTIVE+H_BLANK)*(V_ACTIVE+V_BLANK) cycles, which is 420000 with the defaults.
- Addresses are strictly sequential 0..H_ACTIVE*V_ACTIVE-1 per frame, with no repeats or skips.

## Configuration
- `PIXEL_TX_TESTPATTERN_EN`:
  - Defined: memory is not read. `mem_rd_en`=0 and `mem_rd_addr`=0 always. The active pixel is {`v_cnt`[7:0], `h_cnt`[7:0], 8'h00}, using counters delayed to align with the sync outputs.
  - Undefined: memory-driven operation as above.
  - Timing and syncs are identical in both modes.

## Structure
- Shared package `video_pkg`:
  - constants H_ACTIVE, V_ACTIVE, H_BLANK, V_BLANK, PIX_W=24
  - typedef `pixel_t` (24-bit RGB)
  - state enum `tx_state_t`
- Sub-module `video_timing_gen` owns `h_cnt`/`v_cnt`, the wrap logic and the active/last-cycle flags. `pixel_stream_tx` adds the FSM, address counter and output register.

## Test plan
- Reset, then `start` one cycle with `continuous`=0 and memory holding addr→{5'b0,addr}:
  - exactly 307200 valid pixels, pixel n equals n
  - `frame_done` once, at cycle 420000 after `start`
  - `busy` low 1 cycle later
- Count per-line valid cycles and `VSYNC`-high cycles: 640 valid cycles per line, 160 `HSYNC`-low cycles per line, `VSYNC` high for 480*800 cycles.
- `continuous`=1 for two frames: second frame's first valid pixel exactly 420000 cycles after the first frame's, addr restarts at 0.
- `start` pulsed mid-frame: no effect, one frame only.
- `resetn` low at row 100 col 300: all outputs 0 immediately, and no activity until the next `start`.
- With `PIXEL_TX_TESTPATTERN_EN` defined: pixel at row 3 col 258 = 24'h030200, and `mem_rd_en` is never high.

Source files
------------

// File: rtl/pixel_stream_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_pkg
//  Brief    : Shared raster constants, pixel type and transmitter state enum.
//  Revision : 1.0  initial release
// ============================================================================
package video_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_BLANK  = 160;
    localparam int V_BLANK  = 45;
    localparam int PIX_W    = 24;
    localparam int ADDR_W   = 19;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_stream_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_tx_if
//  Brief    : Synchronous frame-memory read bus (read data one cycle late).
//  Revision : 1.0  initial release
// ============================================================================
interface pixel_stream_tx_if #(
    parameter int ADDR_W = video_pkg::ADDR_W
);
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    video_pkg::pixel_t   mem_rd_data;

    modport master (output mem_rd_en, output mem_rd_addr, input  mem_rd_data);
    modport slave  (input  mem_rd_en, input  mem_rd_addr, output mem_rd_data);
endinterface
`default_nettype wire

// File: rtl/pixel_stream_tx_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Brief    : Horizontal/vertical raster counters with wrap, active-region and
//             last-cycle-of-frame flags. Counters advance only while enabled.
//  Revision : 1.0  initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE,
    parameter int H_BLANK  = video_pkg::H_BLANK,
    parameter int V_BLANK  = video_pkg::V_BLANK,
    parameter int HW       = $clog2(H_ACTIVE + H_BLANK),
    parameter int VW       = $clog2(V_ACTIVE + V_BLANK)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_en,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_line_active,
    output logic          o_last
);

    localparam logic [HW-1:0] c_H_ACTIVE = HW'(H_ACTIVE);
    localparam logic [VW-1:0] c_V_ACTIVE = VW'(V_ACTIVE);
    localparam logic [HW-1:0] c_H_LAST   = HW'(H_ACTIVE + H_BLANK - 1);
    localparam logic [VW-1:0] c_V_LAST   = VW'(V_ACTIVE + V_BLANK - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last      = (r_h_cnt == c_H_LAST);
    assign w_v_last      = (r_v_cnt == c_V_LAST);
    assign o_last        = w_h_last && w_v_last;
    assign o_line_active = (r_v_cnt < c_V_ACTIVE);
    assign o_active      = (r_h_cnt < c_H_ACTIVE) && o_line_active;
    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;

    // Raster position: column wraps into the next line, last line wraps to 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_tx
//  Brief    : Raster pixel-stream transmitter. Reads a frame from synchronous
//             memory and emits pixel_out/HSYNC/VSYNC with blanking, one frame
//             per start or back-to-back while continuous is held.
//             Build option PIXEL_TX_TESTPATTERN_EN: replaces memory data with
//             a {row, col, 0} test pattern and never reads memory.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_stream_tx
    import video_pkg::*;
#(
    parameter int H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE,
    parameter int H_BLANK  = video_pkg::H_BLANK,
    parameter int V_BLANK  = video_pkg::V_BLANK,
    parameter int ADDR_W   = video_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                continuous,
    pixel_stream_tx_if.master   mem,
    output pixel_t              pixel_out,
    output logic                HSYNC,
    output logic                VSYNC,
    output logic                busy,
    output logic                frame_done
);

    localparam int HW = $clog2(H_ACTIVE + H_BLANK);
    localparam int VW = $clog2(V_ACTIVE + V_BLANK);

    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_active;
    logic          w_line_active;
    logic          w_last;
    logic          w_run;
    logic          w_rd;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_frame_done;

    assign w_run = (r_state == ST_RUN);
    assign w_rd  = w_run && w_active;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_BLANK  (V_BLANK),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk           (clk),
        .resetn        (resetn),
        .i_en          (w_run),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_active      (w_active),
        .o_line_active (w_line_active),
        .o_last        (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state: start only accepted in IDLE; one drain cycle after a last frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last && !continuous) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output stage: syncs delayed one cycle to line up with memory read latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_hsync      <= w_rd;
            r_vsync      <= w_run && w_line_active;
            r_frame_done <= w_run && w_last;
        end
    end

    assign HSYNC      = r_hsync;
    assign VSYNC      = r_vsync;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != ST_IDLE);

`ifdef PIXEL_TX_TESTPATTERN_EN
    logic [7:0] r_h_tp;
    logic [7:0] r_v_tp;
    logic       w_unused_rd_data;

    // Counter copies delayed to the same cycle as the sync outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h_tp <= '0;
            r_v_tp <= '0;
        end else begin
            r_h_tp <= 8'(w_h_cnt);
            r_v_tp <= 8'(w_v_cnt);
        end
    end

    assign mem.mem_rd_en   = 1'b0;
    assign mem.mem_rd_addr = '0;
    assign pixel_out       = r_hsync ? {r_v_tp, r_h_tp, 8'h00} : '0;
    assign w_unused_rd_data = ^mem.mem_rd_data;
`else
    logic [ADDR_W-1:0] r_addr;
    logic              w_unused_cnt;

    // Linear read address: +1 per read, back to 0 on the frame's last cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              r_addr <= '0;
        else if (w_run && w_last) r_addr <= '0;
        else if (w_rd)            r_addr <= r_addr + ADDR_W'(1);
    end

    assign mem.mem_rd_en   = w_rd;
    assign mem.mem_rd_addr = r_addr;
    assign pixel_out       = r_hsync ? mem.mem_rd_data : '0;
    assign w_unused_cnt    = ^{w_h_cnt, w_v_cnt};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_stream_tx
//  Brief    : Self-checking bench for pixel_stream_tx on a reduced raster.
//             Expected stream derived from frame position arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_stream_tx;
    import video_pkg::*;

    localparam int HA    = 16;
    localparam int VA    = 8;
    localparam int HB    = 4;
    localparam int VB    = 2;
    localparam int AW    = 8;
    localparam int HT    = HA + HB;
    localparam int FRAME = HT * (VA + VB);
    localparam int NPIX  = HA * VA;
`ifdef PIXEL_TX_TESTPATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   resetn = 1'b0;
    logic   start = 1'b0;
    logic   continuous = 1'b0;
    pixel_t pixel_out;
    logic   hsync, vsync, busy, frame_done;

    int checks = 0;
    int errors = 0;

    pixel_t mem [256];

    pixel_stream_tx_if #(.ADDR_W(AW)) mem_if ();

    pixel_stream_tx #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .V_BLANK  (VB),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .continuous (continuous),
        .mem        (mem_if.master),
        .pixel_out  (pixel_out),
        .HSYNC      (hsync),
        .VSYNC      (vsync),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous frame memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_if.mem_rd_en) mem_if.mem_rd_data <= mem[mem_if.mem_rd_addr];
    end

    function automatic pixel_t pixel_of(input int r, input int c);
        if (TP) return {8'(r), 8'(c), 8'h00};
        return mem[r * HA + c];
    endfunction

    // Expected observation o cycles after the edge that accepted start.
    function automatic void expect_at(input int o, input int nf,
                                      output logic e_h, output logic e_v,
                                      output pixel_t e_pix, output logic e_busy,
                                      output logic e_fd, output logic e_en,
                                      output logic [AW-1:0] e_addr);
        int p, r, c;
        e_h = 1'b0; e_v = 1'b0; e_pix = '0; e_en = 1'b0; e_addr = '0;
        e_busy = (o >= 0) && (o <= nf * FRAME);
        e_fd   = (o > 0) && (o <= nf * FRAME) && (o % FRAME == 0);
        p = o - 1;
        if (p >= 0 && p < nf * FRAME) begin
            r = (p % FRAME) / HT;
            c = p % HT;
            e_v = (r < VA);
            e_h = e_v && (c < HA);
            if (e_h) e_pix = pixel_of(r, c);
        end
        if (!TP && o >= 0 && o < nf * FRAME) begin
            r = (o % FRAME) / HT;
            c = o % HT;
            e_en = (r < VA) && (c < HA);
            e_addr = AW'(r * HA + c);
        end
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hsync, vsync, pixel_out, busy, frame_done, mem_if.mem_rd_en, mem_if.mem_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state got h=%b v=%b pix=%h busy=%b fd=%b en=%b addr=%0d want all zero",
                     hsync, vsync, pixel_out, busy, frame_done, mem_if.mem_rd_en, mem_if.mem_rd_addr);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Runs nf frames from one start; optional start pokes and mid-frame reset.
    task automatic run_frames(input int nf, input bit poke, input int abort_at);
        logic e_h, e_v, e_busy, e_fd, e_en;
        pixel_t e_pix;
        logic [AW-1:0] e_addr;
        int nvalid = 0;
        int nvs = 0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start = 1'b1;
        continuous = (nf > 1);
        @(negedge clk);
        start = 1'b0;
        for (int o = 0; o <= nf * FRAME + 3; o++) begin
            if (abort_at >= 0 && o == abort_at) begin
                #1 resetn = 1'b0;
                #1;
                checks++;
                if ({hsync, vsync, pixel_out, busy, frame_done, mem_if.mem_rd_en, mem_if.mem_rd_addr} !== '0) begin
                    errors++;
                    $display("FAIL async_reset got h=%b v=%b pix=%h busy=%b fd=%b en=%b addr=%0d want all zero",
                             hsync, vsync, pixel_out, busy, frame_done, mem_if.mem_rd_en, mem_if.mem_rd_addr);
                end
                continuous = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                return;
            end
            expect_at(o, nf, e_h, e_v, e_pix, e_busy, e_fd, e_en, e_addr);
            checks++;
            if ({hsync, vsync, pixel_out} !== {e_h, e_v, e_pix}) begin
                errors++;
                $display("FAIL stream o=%0d got h=%b v=%b pix=%h want h=%b v=%b pix=%h",
                         o, hsync, vsync, pixel_out, e_h, e_v, e_pix);
            end
            checks++;
            if ({busy, frame_done} !== {e_busy, e_fd}) begin
                errors++;
                $display("FAIL control o=%0d got busy=%b fd=%b want busy=%b fd=%b",
                         o, busy, frame_done, e_busy, e_fd);
            end
            checks++;
            if (mem_if.mem_rd_en !== e_en || ((e_en || TP) && mem_if.mem_rd_addr !== e_addr)) begin
                errors++;
                $display("FAIL mem_read o=%0d got en=%b addr=%0d want en=%b addr=%0d",
                         o, mem_if.mem_rd_en, mem_if.mem_rd_addr, e_en, e_addr);
            end
            if (hsync && vsync) nvalid++;
            if (vsync) nvs++;
            start = poke && (o == FRAME / 2 || o == nf * FRAME);
            if (nf > 1 && o == (nf - 1) * FRAME + 3) continuous = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (nvalid != nf * NPIX || nvs != nf * VA * HT) begin
            errors++;
            $display("FAIL totals got valid=%0d vsync=%0d want valid=%0d vsync=%0d",
                     nvalid, nvs, nf * NPIX, nf * VA * HT);
        end
    endtask

    task automatic test_idle(input int ncyc);
        logic e_h, e_v, e_busy, e_fd, e_en;
        pixel_t e_pix;
        logic [AW-1:0] e_addr;
        for (int i = 0; i < ncyc; i++) begin
            expect_at(-1, 0, e_h, e_v, e_pix, e_busy, e_fd, e_en, e_addr);
            checks++;
            if ({hsync, vsync, pixel_out, busy, frame_done, mem_if.mem_rd_en} !== {e_h, e_v, e_pix, e_busy, e_fd, e_en}) begin
                errors++;
                $display("FAIL idle i=%0d got h=%b v=%b pix=%h busy=%b fd=%b en=%b want quiet",
                         i, hsync, vsync, pixel_out, busy, frame_done, mem_if.mem_rd_en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_frame();
        run_frames(1, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_frames(int'($urandom_range(2, 3)), 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        run_frames(1, 1'b1, -1);
        test_idle(FRAME / 4);
    endtask

    task automatic test_reset_mid_frame();
        run_frames(1, 1'b0, 1 + 3 * HT + 5);
        test_idle(2 * FRAME);
        run_frames(1, 1'b0, -1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = pixel_t'($urandom);
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_idle(10);
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_frame();
        for (int i = 0; i < 256; i++) mem[i] = pixel_t'($urandom);
        test_single_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
